// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a multicycle MIPS-style datapath. It is a Moore machine
//   that walks each instruction through FETCH/DECODE and then its execute/
//   memory/writeback states. It also counts retired instructions.
//
// Ports
//   clk            rising-edge clock (single domain)
//   rst            synchronous, active-high reset
//   OpCode[5:0]    instruction opcode; captured in DECODE only
//   mem_ready      memory handshake, used in FETCH / MEMRD / MEMWR
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst            1-bit datapath controls
//   PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0]  mux / ALU selects
//   state[3:0]     current FSM state encoding
//   illegal_op     single-cycle pulse when DECODE sees an unsupported opcode
//   instr_retired  retired-instruction count, wraps at all-ones
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ_EX   = 4'd8,
    S_JUMP     = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // ---------------------------------------------------------------------------
  // State, latched opcode and retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'b000000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter wraps naturally from all-ones to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // IR load and PC+4 happen only on the cycle memory delivers.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        op_d    = OpCode;
        case (OpCode)
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ_EX;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Unsupported opcode: flag it and drop back to fetch unretired.
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // Only lw/sw reach here; branch on the copy taken in DECODE.
        state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end

      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RTYPE_WB;
      end

      S_RTYPE_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

      S_BEQ_EX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end

      // Unused encodings recover to FETCH quietly, nothing retired.
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control immediately, not just after the edge.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcB     = 2'b00;
      illegal_op  = 1'b0;
    end
  end

  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int CW = 4;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    OpCode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic          IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]    PCSource, ALUOp, ALUSrcB;
  logic [3:0]    state;
  logic          illegal_op;
  logic [CW-1:0] instr_retired;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .state(state), .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  // Packed control view: [15]PCWrite [14]PCWriteCond [13]IorD [12]MemRead
  // [11]MemWrite [10]MemtoReg [9]IRWrite [8]ALUSrcA [7]RegWrite [6]RegDst
  // [5:4]PCSource [3:2]ALUOp [1:0]ALUSrcB
  logic [15:0] dut_ctrl;
  assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an instruction is a list of states chosen at DECODE;
  // finishing the list retires it. Wait states stall on mem_ready=0.
  // ---------------------------------------------------------------------------
  int m_state = 0;
  int m_cnt   = 0;
  int m_path[$];

  function automatic logic [15:0] ctrl_of(input int s, input bit mr);
    case (s)
      0: return mr ? 16'h9201 : 16'h1001;
      1: return 16'h0003;
      2: return 16'h0102;
      3: return 16'h3000;
      4: return 16'h0480;
      5: return 16'h2800;
      6: return 16'h0108;
      7: return 16'h00C0;
      8: return 16'h4114;
      9: return 16'h8020;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == JMP;
  endfunction

  task automatic model_advance();
    if (m_path.size() > 0) m_state = m_path.pop_front();
    else begin
      m_state = 0;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic model_step(input logic r, input logic [5:0] op, input logic mr);
    if (r) begin
      m_state = 0; m_cnt = 0; m_path.delete();
    end else begin
      case (m_state)
        0: if (mr) m_state = 1;
        1: begin
          m_path.delete();
          if      (op == LW)  m_path = '{2, 3, 4};
          else if (op == SW)  m_path = '{2, 5};
          else if (op == RT)  m_path = '{6, 7};
          else if (op == BEQ) m_path = '{8};
          else if (op == JMP) m_path = '{9};
          // Illegal: empty path, go home without retiring.
          if (m_path.size() == 0) m_state = 0;
          else m_state = m_path.pop_front();
        end
        3, 5: if (mr) model_advance();
        default: model_advance();
      endcase
    end
  endtask

  logic [3:0]    obs_state;
  logic [15:0]   obs_ctrl;
  logic          obs_ill;
  logic [CW-1:0] obs_cnt;

  // One clock: drive, sample mid-cycle, optionally compare to model, clock.
  task automatic cycle(input logic r, input logic [5:0] op, input logic mr, input bit use_model);
    rst = r; OpCode = op; mem_ready = mr;
    #2;
    obs_state = state; obs_ctrl = dut_ctrl; obs_ill = illegal_op; obs_cnt = instr_retired;
    if (use_model) begin
      chk("model_state", {28'd0, obs_state}, m_state);
      chk("model_ctrl", {16'd0, obs_ctrl}, r ? 32'd0 : {16'd0, ctrl_of(m_state, mr)});
      chk("model_illegal", {31'd0, obs_ill}, (!r && m_state == 1 && !legal(op)) ? 32'd1 : 32'd0);
      chk("model_count", {28'd0, obs_cnt}, m_cnt);
    end
    @(posedge clk);
    model_step(r, op, mr);
    #1;
  endtask

  typedef struct {
    logic          r;
    logic [5:0]    op;
    logic          mr;
    logic [3:0]    st;
    logic [15:0]   ctrl;
    logic          ill;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[16];
  int   wcnt;

  initial begin
    tbl[0]  = '{1'b0, LW,  1'b1, 4'd0, 16'h9201, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, LW,  1'b1, 4'd1, 16'h0003, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, LW,  1'b1, 4'd2, 16'h0102, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, LW,  1'b1, 4'd3, 16'h3000, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, LW,  1'b1, 4'd4, 16'h0480, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, RT,  1'b1, 4'd0, 16'h9201, 1'b0, 4'd1};
    tbl[6]  = '{1'b0, RT,  1'b1, 4'd1, 16'h0003, 1'b0, 4'd1};
    tbl[7]  = '{1'b0, RT,  1'b1, 4'd6, 16'h0108, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, RT,  1'b1, 4'd7, 16'h00C0, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, BAD, 1'b1, 4'd0, 16'h9201, 1'b0, 4'd2};
    tbl[10] = '{1'b0, BAD, 1'b1, 4'd1, 16'h0003, 1'b1, 4'd2};
    tbl[11] = '{1'b0, BAD, 1'b1, 4'd0, 16'h9201, 1'b0, 4'd2};
    tbl[12] = '{1'b0, BAD, 1'b0, 4'd1, 16'h0003, 1'b1, 4'd2};
    tbl[13] = '{1'b0, LW,  1'b0, 4'd0, 16'h1001, 1'b0, 4'd2};
    tbl[14] = '{1'b1, LW,  1'b1, 4'd0, 16'h0000, 1'b0, 4'd2};
    tbl[15] = '{1'b1, RT,  1'b0, 4'd0, 16'h0000, 1'b0, 4'd0};

    // Reset
    rst = 1'b1; OpCode = RT; mem_ready = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, LW, 1'b1, 1'b1);
    chk("reset_state", {28'd0, obs_state}, 32'd0);
    chk("reset_ctrl_forced", {16'd0, obs_ctrl}, 32'd0);
    chk("reset_count", {28'd0, obs_cnt}, 32'd0);

    // Table: lw, R-type, illegal, reset during FETCH
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].r, tbl[i].op, tbl[i].mr, 1'b0);
      chk($sformatf("tbl%0d_state", i), {28'd0, obs_state}, {28'd0, tbl[i].st});
      chk($sformatf("tbl%0d_ctrl", i), {16'd0, obs_ctrl}, {16'd0, tbl[i].ctrl});
      chk($sformatf("tbl%0d_illegal", i), {31'd0, obs_ill}, {31'd0, tbl[i].ill});
      chk($sformatf("tbl%0d_count", i), {28'd0, obs_cnt}, {28'd0, tbl[i].cnt});
    end

    // sw, 3 wait cycles in MEMWR; opcode changed after DECODE must not matter
    cycle(1'b0, SW, 1'b1, 1'b1);
    cycle(1'b0, SW, 1'b1, 1'b1);
    cycle(1'b0, LW, 1'b1, 1'b1);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, LW, (i == 3), 1'b1);
      if (obs_ctrl[11] === 1'b1) wcnt++;
    end
    chk("sw_memwrite_cycles", wcnt, 32'd4);

    // FETCH waits 2 cycles, then beq
    cycle(1'b0, BEQ, 1'b0, 1'b1);
    chk("sw_back_to_fetch", {28'd0, obs_state}, 32'd0);
    chk("sw_retired_once", {28'd0, obs_cnt}, 32'd1);
    chk("fwait0_irw_pcw", {30'd0, obs_ctrl[9], obs_ctrl[15]}, 32'd0);
    cycle(1'b0, BEQ, 1'b0, 1'b1);
    chk("fwait1_irw_pcw", {30'd0, obs_ctrl[9], obs_ctrl[15]}, 32'd0);
    cycle(1'b0, BEQ, 1'b1, 1'b1);
    chk("fdone_irw_pcw", {30'd0, obs_ctrl[9], obs_ctrl[15]}, 32'd3);
    cycle(1'b0, BEQ, 1'b1, 1'b1);
    chk("decode_irw_low", {31'd0, obs_ctrl[9]}, 32'd0);
    cycle(1'b0, BAD, 1'b1, 1'b1);
    chk("beq_state", {28'd0, obs_state}, 32'd8);
    chk("beq_pcwritecond", {31'd0, obs_ctrl[14]}, 32'd1);
    chk("beq_pcsource", {30'd0, obs_ctrl[5:4]}, 32'd1);

    // Reset while waiting in MEMRD aborts the lw
    cycle(1'b0, LW, 1'b1, 1'b1);
    cycle(1'b0, LW, 1'b1, 1'b1);
    cycle(1'b0, LW, 1'b1, 1'b1);
    cycle(1'b0, LW, 1'b0, 1'b1);
    chk("memrd_wait_state", {28'd0, obs_state}, 32'd3);
    cycle(1'b1, LW, 1'b0, 1'b1);
    chk("rst_in_memrd_ctrl", {16'd0, obs_ctrl}, 32'd0);
    cycle(1'b0, LW, 1'b1, 1'b1);
    chk("after_rst_state", {28'd0, obs_state}, 32'd0);
    chk("after_rst_fetch_ctrl", {16'd0, obs_ctrl}, 32'h9201);
    chk("after_rst_count", {28'd0, obs_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, LW, 1'b1, 1'b1);

    // Counter wrap via jumps
    for (int k = 0; k < 20 && m_cnt != 15; k++)
      for (int i = 0; i < 3; i++) cycle(1'b0, JMP, 1'b1, 1'b1);
    cycle(1'b0, JMP, 1'b1, 1'b1);
    cycle(1'b0, JMP, 1'b1, 1'b1);
    cycle(1'b0, RT, 1'b1, 1'b1);
    chk("jump_state", {28'd0, obs_state}, 32'd9);
    chk("jump_pcsource", {30'd0, obs_ctrl[5:4]}, 32'd2);
    chk("count_all_ones", {28'd0, obs_cnt}, 32'd15);
    cycle(1'b0, RT, 1'b1, 1'b1);
    chk("count_wrapped", {28'd0, obs_cnt}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      logic       mr, r;
      case ($urandom_range(0, 5))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = JMP;
        default: op = 6'($urandom_range(0, 63));
      endcase
      mr = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 49) == 0);
      cycle(r, op, mr, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
